alu_seq: RTL and testbench

- Parametrised, handshaked successor to the combinational integer ALU in the execute stage.
- Base RV32I ALU ops return in one registered cycle.
- M-extension multiply/divide ops run iteratively, one bit per cycle.
- Sits between the decode/issue register and the writeback mux; valid/ready on both sides lets the pipeline stall on long ops.

---
 rtl/alu_seq.sv | 241 ++++++++++++++++++++++++
 tb/tb_alu_seq.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq -- handshaked execute-stage ALU with an iterative multiply/divide unit
//
// Base RV32I ops (s[4]=0) produce a registered result one cycle after accept.
// M-extension ops (s[4]=1) run a radix-2 shift-add multiplier or a restoring
// divider on operand magnitudes. The datapath retires one bit per cycle, and
// the sign is corrected on the final step. Divide-by-zero and signed overflow
// are resolved at accept time and use the base latency.
//
// Handshake: an op is accepted on a rising edge with in_valid && in_ready.
// in_ready depends only on the FSM state (high in IDLE) and never on in_valid.
// A result is presented with out_valid=1 and o is held stable until the edge
// where out_ready=1 consumes it. The block takes no new op on that same edge.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   operation request
//   in_ready   block can accept an operation this cycle
//   i0, i1     operands A (rs1) and B (rs2/imm)
//   s          opcode: s[4]=M-extension, s[3:0] selects the operation
//   out_valid  result o is valid
//   out_ready  consumer accepts the result
//   o          registered result
//   dbg_state  current FSM state (IDLE=0, BUSY=1, DONE=2)
// -----------------------------------------------------------------------------
module alu_seq #(
  parameter int WIDTH  = 32,
  parameter int MDU_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic [4:0]       s,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] o,
  output logic [1:0]       dbg_state
);

  localparam int SW = $clog2(WIDTH);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int W2 = 2 * WIDTH;
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  logic [CW-1:0]  cnt;     // remaining iteration steps
  logic [W2-1:0]  acc;     // mul: {partial product, multiplier}; div: {remainder, quotient}
  logic [WIDTH-1:0] opb;   // mul: multiplicand magnitude; div: divisor magnitude
  logic [2:0]     op_r;    // latched M sub-opcode
  logic           neg_r;   // final result must be negated

  assign in_ready  = (state == IDLE);
  assign dbg_state = state;

  // ---------------------------------------------------------------------------
  // Base ALU (single cycle, computed from the live inputs at accept)
  // ---------------------------------------------------------------------------
  logic [SW-1:0]    shamt;
  logic [WIDTH-1:0] base_res;

  always_comb begin
    shamt    = i1[SW-1:0];
    base_res = '0;
    case (s[3:0])
      4'b0000: base_res = i0 + i1;
      4'b1000: base_res = i0 - i1;
      4'b0001: base_res = i0 << shamt;
      4'b0010: base_res = {{(WIDTH-1){1'b0}}, ($signed(i0) < $signed(i1))};
      4'b0011: base_res = {{(WIDTH-1){1'b0}}, (i0 < i1)};
      4'b0100: base_res = i0 ^ i1;
      4'b0101: base_res = i0 >> shamt;
      4'b1101: base_res = $unsigned($signed(i0) >>> shamt);
      4'b0110: base_res = i0 | i1;
      4'b0111: base_res = i0 & i1;
      default: base_res = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // M-op accept decode: operand signedness, magnitudes and short-cut results
  // ---------------------------------------------------------------------------
  logic [2:0]       mop;
  logic             a_sgn, b_sgn, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             div_zero, div_ovf, quick;
  logic [WIDTH-1:0] quick_res;
  logic             neg_in;

  always_comb begin
    mop   = s[2:0];
    // MULH, MULHSU, DIV and REM treat i0 as signed; MULH, DIV and REM treat i1 as signed.
    a_sgn = (mop == 3'b001) || (mop == 3'b010) || (mop == 3'b100) || (mop == 3'b110);
    b_sgn = (mop == 3'b001) || (mop == 3'b100) || (mop == 3'b110);
    a_neg = a_sgn && i0[WIDTH-1];
    b_neg = b_sgn && i1[WIDTH-1];
    // Negating the most-negative value yields itself, which is the correct
    // unsigned magnitude.
    a_mag = a_neg ? (~i0 + 1'b1) : i0;
    b_mag = b_neg ? (~i1 + 1'b1) : i1;

    div_zero = mop[2] && (i1 == '0);
    div_ovf  = mop[2] && !mop[0] && (i0 == MOST_NEG) && (i1 == '1);

    // Remainder carries the dividend sign; product and quotient carry the XOR.
    neg_in = (mop[2] && mop[1]) ? a_neg : (a_neg ^ b_neg);

    quick     = (MDU_EN == 0) || div_zero || div_ovf;
    quick_res = '0;
    if (MDU_EN == 0) begin
      quick_res = '0;
    end else if (div_zero) begin
      quick_res = mop[1] ? i0 : '1;
    end else if (div_ovf) begin
      quick_res = mop[1] ? '0 : i0;
    end
  end

  // ---------------------------------------------------------------------------
  // One iteration of the shared shift register
  // ---------------------------------------------------------------------------
  logic [WIDTH:0]  mul_sum;
  logic [WIDTH:0]  div_shift;
  logic [WIDTH:0]  div_diff;
  logic [W2-1:0]   step_acc;

  always_comb begin
    // Multiply: add the multiplicand into the upper half when the multiplier
    // LSB is set, then shift the whole register right by one.
    mul_sum   = {1'b0, acc[W2-1:WIDTH]} + (acc[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
    // Divide: shift the next dividend bit into the remainder and trial-subtract.
    // The remainder always stays below the divisor, so a W+1 bit difference
    // holds both outcomes and its MSB is the borrow.
    div_shift = acc[W2-1:WIDTH-1];
    div_diff  = div_shift - {1'b0, opb};
    if (op_r[2]) begin
      if (!div_diff[WIDTH]) begin
        step_acc = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end else begin
        step_acc = {acc[W2-2:0], 1'b0};
      end
    end else begin
      step_acc = {mul_sum, acc[WIDTH-1:1]};
    end
  end

  // ---------------------------------------------------------------------------
  // Final sign correction and result selection (used on the last step)
  // ---------------------------------------------------------------------------
  logic [W2-1:0]    prod;
  logic [WIDTH-1:0] dres;
  logic [WIDTH-1:0] fin_res;

  always_comb begin
    prod = neg_r ? (~step_acc + 1'b1) : step_acc;
    dres = op_r[1] ? step_acc[W2-1:WIDTH] : step_acc[WIDTH-1:0];
    if (neg_r) begin
      dres = ~dres + 1'b1;
    end
    if (op_r[2]) begin
      fin_res = dres;
    end else if (op_r[1:0] == 2'b00) begin
      fin_res = prod[WIDTH-1:0];
    end else begin
      fin_res = prod[W2-1:WIDTH];
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      o         <= '0;
      cnt       <= '0;
      acc       <= '0;
      opb       <= '0;
      op_r      <= '0;
      neg_r     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (!s[4]) begin
              o         <= base_res;
              out_valid <= 1'b1;
              state     <= DONE;
            end else if (quick) begin
              o         <= quick_res;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              // Divide shifts the dividend out of the low half; multiply
              // shifts the multiplier out of it.
              acc   <= mop[2] ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
              opb   <= mop[2] ? b_mag : a_mag;
              op_r  <= mop;
              neg_r <= neg_in;
              cnt   <= CW'(WIDTH);
              state <= BUSY;
            end
          end
        end

        BUSY: begin
          acc <= step_acc;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            o         <= fin_res;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_seq -- self-checking bench for alu_seq (WIDTH=32, MDU_EN=1)
//
// Directed vectors cover the listed corner cases. Random ops are checked
// against a reference model built on 64-bit integer arithmetic. Reset,
// backpressure and latency behaviour are checked cycle by cycle.
// -----------------------------------------------------------------------------
module tb_alu_seq;

  localparam int W = 32;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] i0;
  logic [W-1:0] i1;
  logic [4:0]   s;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] o;
  logic [1:0]   dbg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W), .MDU_EN(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .i0        (i0),
    .i1        (i1),
    .s         (s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .o         (o),
    .dbg_state (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  logic [W-1:0] exp_q[$];
  int n_checks;
  int n_fail;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: plain 64-bit integer arithmetic on the operand values.
  function automatic logic [W-1:0] model(input logic [4:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    longint          sa, sb, sbu;
    longint unsigned ua, ub;
    logic [63:0]     p;
    logic [W-1:0]    r;
    sa  = $signed(a);
    sb  = $signed(b);
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    sbu = longint'(ub);
    r   = '0;
    if (!op[4]) begin
      case (op[3:0])
        4'b0000: r = a + b;
        4'b1000: r = a - b;
        4'b0001: r = a << b[4:0];
        4'b0010: r = (sa < sb) ? 32'd1 : 32'd0;
        4'b0011: r = (a < b) ? 32'd1 : 32'd0;
        4'b0100: r = a ^ b;
        4'b0101: r = a >> b[4:0];
        4'b1101: begin p = sa >>> b[4:0]; r = p[31:0]; end
        4'b0110: r = a | b;
        4'b0111: r = a & b;
        default: r = '0;
      endcase
    end else begin
      case (op[2:0])
        3'b000: begin p = sa * sb;  r = p[31:0];  end
        3'b001: begin p = sa * sb;  r = p[63:32]; end
        3'b010: begin p = sa * sbu; r = p[63:32]; end
        3'b011: begin p = ua * ub;  r = p[63:32]; end
        3'b100: begin
          if (b == '0) r = '1;
          else begin p = sa / sb; r = p[31:0]; end
        end
        3'b101: r = (b == '0) ? '1 : a / b;
        3'b110: begin
          if (b == '0) r = a;
          else begin p = sa % sb; r = p[31:0]; end
        end
        default: r = (b == '0) ? a : a % b;
      endcase
    end
    return r;
  endfunction

  function automatic int model_lat(input logic [4:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b);
    if (!op[4]) return 1;
    if (op[2] && (b == '0)) return 1;
    if (op[2] && !op[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) return 1;
    return W + 1;
  endfunction

  // ---------------------------------------------------------------------------
  // Driver: issue one op, check busy/latency/result, hold, then consume
  // ---------------------------------------------------------------------------
  task automatic run_op(input string tag, input logic [4:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp, input int hold);
    int waitc;
    int lat;
    logic [W-1:0] exp_v;
    waitc = 0;
    while (!in_ready && waitc < 100) begin
      @(posedge clk); #1;
      waitc++;
    end
    if (waitc >= 100) check({tag, "_ready_timeout"}, 32'd0, 32'd1);
    in_valid = 1'b1;
    i0 = a;
    i1 = b;
    s  = op;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    // Scramble the inputs after accept: operands must already be captured.
    in_valid = 1'b0;
    i0 = $urandom;
    i1 = $urandom;
    s  = 5'($urandom);
    lat = 1;
    while (!out_valid && lat < 100) begin
      check({tag, "_in_ready_busy"}, 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      lat++;
    end
    exp_v = exp_q.pop_front();
    check({tag, "_latency"}, 32'(lat), 32'(model_lat(op, a, b)));
    check({tag, "_result"}, o, exp_v);
    check({tag, "_done_in_ready"}, 32'(in_ready), 32'd0);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      check({tag, "_hold_o"}, o, exp_v);
      check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_consumed"}, 32'(out_valid), 32'd0);
    check({tag, "_ready_after"}, 32'(in_ready), 32'd1);
  endtask

  function automatic logic [W-1:0] pick_val();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [4:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
  } vec_t;
  vec_t dir_v[$];

  task automatic add_vec(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.exp = exp;
    dir_v.push_back(v);
  endtask

  initial begin
    int seen;
    logic [4:0]   rop;
    logic [W-1:0] ra, rb;
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    i0 = '0; i1 = '0; s = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_o", o, 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);

    // Directed vectors with hand-derived expectations.
    add_vec(5'b01000, 32'd5,          32'd7,          32'hFFFF_FFFE); // SUB
    add_vec(5'b01101, 32'h8000_0000, 32'd4,          32'hF800_0000); // SRA
    add_vec(5'b00010, 32'hFFFF_FFFF, 32'd1,          32'd1);         // SLT
    add_vec(5'b00011, 32'hFFFF_FFFF, 32'd1,          32'd0);         // SLTU
    add_vec(5'b01001, 32'd123,        32'd456,        32'd0);         // undefined code
    add_vec(5'b00000, 32'hFFFF_FFFF, 32'd1,          32'd0);         // ADD wraps
    add_vec(5'b00001, 32'd1,          32'd31,         32'h8000_0000); // SLL
    add_vec(5'b00101, 32'h8000_0000, 32'd33,         32'h4000_0000); // SRL uses low 5 bits
    add_vec(5'b10001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000); // MULH
    add_vec(5'b10011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE); // MULHU
    add_vec(5'b10000, 32'd12345,      32'd6789,       32'd83810205);  // MUL
    add_vec(5'b10010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF); // MULHSU
    add_vec(5'b11000, 32'd3,          32'd5,          32'd15);        // s[3] ignored
    add_vec(5'b10100, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD); // DIV -7/2
    add_vec(5'b10110, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF); // REM -7/2
    add_vec(5'b10101, 32'd100,        32'd7,          32'd14);        // DIVU
    add_vec(5'b10111, 32'd100,        32'd7,          32'd2);         // REMU
    add_vec(5'b10100, 32'd1234,       32'd0,          32'hFFFF_FFFF); // DIV by zero
    add_vec(5'b10111, 32'd55,         32'd0,          32'd55);        // REMU by zero
    add_vec(5'b10110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);         // REM overflow
    add_vec(5'b10100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000); // DIV overflow
    foreach (dir_v[k]) begin
      run_op($sformatf("dir%0d", k), dir_v[k].op, dir_v[k].a, dir_v[k].b, dir_v[k].exp, 0);
    end

    // Backpressure: result held while a new op waits with in_valid=1.
    in_valid = 1'b1; i0 = 32'd1; i1 = 32'd2; s = 5'b00000;
    @(posedge clk); #1;
    i0 = 32'h0000_F0F0; i1 = 32'h0000_0FF0; s = 5'b00100;
    check("bp_valid", 32'(out_valid), 32'd1);
    for (int k = 0; k < 5; k++) begin
      check("bp_o", o, 32'd3);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_consumed", 32'(out_valid), 32'd0);
    check("bp_ready_next", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_second_valid", 32'(out_valid), 32'd1);
    check("bp_second_o", o, 32'h0000_FF00);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Reset while a result is held in DONE.
    in_valid = 1'b1; i0 = 32'd7; i1 = 32'd8; s = 5'b00000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("rst_done_pre", 32'(out_valid), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_done_valid", 32'(out_valid), 32'd0);
    check("rst_done_o", o, 32'd0);
    check("rst_done_ready", 32'(in_ready), 32'd1);

    // Reset during a multiply: nothing may come out afterwards.
    in_valid = 1'b1; i0 = 32'd99; i1 = 32'd77; s = 5'b10000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_busy_ready", 32'(in_ready), 32'd1);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("rst_busy_no_out", 32'(seen), 32'd0);

    // Randomized ops against the reference model.
    for (int n = 0; n < 150; n++) begin
      rop = 5'($urandom);
      ra  = pick_val();
      rb  = pick_val();
      run_op($sformatf("rnd%0d_s%b", n, rop), rop, ra, rb, model(rop, ra, rb),
             $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
